// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the forwarding register file.
// The read-source enum names where each read port's data comes from.
package regfile_fwd_pkg;

  localparam int REG_NUM      = 32;
  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;

  typedef enum logic [2:0] {
    SRC_ZERO  = 3'd0,
    SRC_EX    = 3'd1,
    SRC_MEM   = 3'd2,
    SRC_WB    = 3'd3,
    SRC_ARRAY = 3'd4
  } read_src_e;

endpackage

// File: rtl/regfile_fwd_sel.sv
// One read port's priority mux: reset/disable/r0 give zero, otherwise the
// youngest in-flight result targeting the address wins over the stored value.
module regfile_fwd_sel
  import regfile_fwd_pkg::*;
#(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          ex_wreg,
  input  logic [AW-1:0] ex_wd,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] stored,
  output logic [DW-1:0] rdata
);

  read_src_e src;
  logic      is_r0;
  logic      ex_hit;
  logic      mem_hit;
  logic      wb_hit;

  assign is_r0   = (ZERO_R0 != 0) && (raddr == '0);
  assign ex_hit  = (ex_wreg == WRITE_ENABLE) && (ex_wd == raddr);
  assign mem_hit = (mem_wreg == WRITE_ENABLE) && (mem_wd == raddr);
  assign wb_hit  = (we == WRITE_ENABLE) && (waddr == raddr);

  // r0 is checked before any forward so a stage targeting r0 never leaks through.
  always_comb begin
    src = SRC_ARRAY;
    if (rst == RST_ENABLE) begin
      src = SRC_ZERO;
    end else if (re != READ_ENABLE) begin
      src = SRC_ZERO;
    end else if (is_r0) begin
      src = SRC_ZERO;
    end else if (ex_hit) begin
      src = SRC_EX;
    end else if (mem_hit) begin
      src = SRC_MEM;
    end else if (wb_hit) begin
      src = SRC_WB;
    end
  end

  always_comb begin
    rdata = '0;
    case (src)
      SRC_ZERO:  rdata = '0;
      SRC_EX:    rdata = ex_wdata;
      SRC_MEM:   rdata = mem_wdata;
      SRC_WB:    rdata = wdata;
      SRC_ARRAY: rdata = stored;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile_fwd.sv
// Architectural register file with two forwarding read ports and one write port.
// Holds the array and write logic; each read port is a regfile_fwd_sel instance.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int NREGS   = REG_NUM,
  parameter int DW      = REG_BUS,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ex_wreg,
  input  logic [AW-1:0] ex_wd,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NREGS];
  logic          write_ok;
  logic [DW-1:0] stored1;
  logic [DW-1:0] stored2;

  assign write_ok = (we == WRITE_ENABLE) && !((ZERO_R0 != 0) && (waddr == '0));

  // Reset wins over a same-cycle write, so the write is simply dropped.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[waddr] <= wdata;
    end
  end

  assign stored1 = regs[raddr1];
  assign stored2 = regs[raddr2];

  regfile_fwd_sel #(
    .AW      (AW),
    .DW      (DW),
    .ZERO_R0 (ZERO_R0)
  ) u_sel1 (
    .rst       (rst),
    .re        (re1),
    .raddr     (raddr1),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stored    (stored1),
    .rdata     (rdata1)
  );

  regfile_fwd_sel #(
    .AW      (AW),
    .DW      (DW),
    .ZERO_R0 (ZERO_R0)
  ) u_sel2 (
    .rst       (rst),
    .re        (re2),
    .raddr     (raddr2),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stored    (stored2),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: stimulus pushes expected read data from an
// array-based reference model; a monitor pops and compares a few ns later.
module tb_regfile_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ex_wreg = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic [31:0] ex_wdata = '0;
  logic        mem_wreg = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic [31:0] mem_wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;

  always #10 clk = ~clk;

  regfile_fwd dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          vectors = 0;
  int          miscompares = 0;
  event        pushed;

  // Reference read: the priority list evaluated directly on the current inputs.
  function automatic logic [31:0] ref_read(logic r_en, logic [4:0] a);
    if (rst) return 32'h0;
    if (!r_en) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (ex_wreg && ex_wd == a) return ex_wdata;
    if (mem_wreg && mem_wd == a) return mem_wdata;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (rdata1 !== e.e1) begin
      miscompares++;
      $display("[TB] FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.e1);
    end
    vectors++;
    if (rdata2 !== e.e2) begin
      miscompares++;
      $display("[TB] FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.e2);
    end
  endtask

  initial begin
    forever begin
      @(pushed);
      #3;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // clocked=0 checks the combinational result without letting an edge pass.
  task automatic applyStimulus(input string name, input bit clocked);
    exp_t e;
    e.name = name;
    e.e1 = ref_read(re1, raddr1);
    e.e2 = ref_read(re2, raddr2);
    sb.push_back(e);
    ->pushed;
    #4;
    if (clocked) begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && waddr != 5'd0) begin
        model[waddr] = wdata;
      end
      #1;
    end
  endtask

  task automatic clearInputs();
    we = 0; waddr = 0; wdata = 0;
    ex_wreg = 0; ex_wd = 0; ex_wdata = 0;
    mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;

    rst = 1; re1 = 1; raddr1 = 5;
    applyStimulus("reset_init", 1);
    applyStimulus("reset_init", 1);
    rst = 0;

    we = 1; waddr = 5; wdata = 32'h1234;
    applyStimulus("t1_write_through", 1);
    we = 0;
    applyStimulus("t1_stored", 1);
    rst = 1; ex_wreg = 1; ex_wd = 5; ex_wdata = 32'h77;
    applyStimulus("t1_rst", 1);
    applyStimulus("t1_rst", 1);
    rst = 0; ex_wreg = 0;
    applyStimulus("t1_after_rst", 1);

    clearInputs();
    we = 1; waddr = 3; wdata = 32'hDEADBEEF;
    applyStimulus("t2_re_off", 1);
    we = 0; re1 = 1; raddr1 = 3;
    applyStimulus("t2_read", 1);
    ex_wreg = 1; ex_wd = 5'b10011; ex_wdata = 32'h0BAD0BAD;
    applyStimulus("full_addr_compare", 0);

    clearInputs();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
    ex_wreg = 1; ex_wd = 0; ex_wdata = 32'h55;
    mem_wreg = 1; mem_wd = 0; mem_wdata = 32'h66;
    re1 = 1; raddr1 = 0;
    applyStimulus("t3_r0_now", 1);
    clearInputs();
    re1 = 1; raddr1 = 0;
    applyStimulus("t3_r0_after", 1);

    clearInputs();
    we = 1; waddr = 7; wdata = 32'h1; re1 = 1; raddr1 = 7;
    applyStimulus("t4_init", 1);
    wdata = 32'h2;
    mem_wreg = 1; mem_wd = 7; mem_wdata = 32'h3;
    ex_wreg = 1; ex_wd = 7; ex_wdata = 32'h4;
    applyStimulus("t4_ex", 0);
    ex_wreg = 0;
    applyStimulus("t4_mem", 0);
    mem_wreg = 0;
    applyStimulus("t4_wb", 0);
    we = 0;
    applyStimulus("t4_array", 1);

    clearInputs();
    mem_wreg = 1; mem_wd = 9; mem_wdata = 32'hA5A5A5A5;
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 9;
    applyStimulus("t5_dual", 0);
    re2 = 0;
    applyStimulus("t5_re2_off", 1);

    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      we = $urandom_range(0, 1) == 1;
      waddr = rand_addr();
      wdata = $urandom();
      ex_wreg = $urandom_range(0, 2) == 0;
      ex_wd = rand_addr();
      ex_wdata = $urandom();
      mem_wreg = $urandom_range(0, 2) == 0;
      mem_wd = rand_addr();
      mem_wdata = $urandom();
      re1 = $urandom_range(0, 7) != 0;
      raddr1 = rand_addr();
      re2 = $urandom_range(0, 7) != 0;
      raddr2 = ($urandom_range(0, 7) == 0) ? raddr1 : rand_addr();
      applyStimulus("t6_random", 1);
    end

    #10;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
